// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS controller.
// State, mux encodings, opcode/funct values and ALU op codes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [1:0] ALU_SRC_REG        = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP26 = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic rtype;
    logic jr;
    logic ialu;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic ill;
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } decoded_t;

  function automatic logic [2:0] funct_alu_op(
    input logic [5:0] f
  );
    case (f)
      FN_SUB, FN_SUBU: return OP_SUB;
      FN_AND:          return OP_AND;
      FN_OR:           return OP_OR;
      FN_XOR:          return OP_XOR;
      FN_NOR:          return OP_NOR;
      FN_SLT:          return OP_SLT;
      default:         return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle.
// master = controller, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] dst_sel;
  logic [1:0] wb_sel;
  logic [1:0] alu_src;
  logic [2:0] alu_op;
  logic       retire;
  logic       trap;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel,
    output ir_write, pc_write, pc_src,
    output reg_write, dst_sel, wb_sel,
    output alu_src, alu_op, retire, trap
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel,
    input  ir_write, pc_write, pc_src,
    input  reg_write, dst_sel, wb_sel,
    input  alu_src, alu_op, retire, trap
  );
endinterface

// File: rtl/multicycle_control_opclass.sv
// Instruction classifier: {opcode, funct} to one-hot class
// plus the ALU op and operand select used in EXEC.
module mc_opclass
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decoded_t   dec
);

  // Pure decode table; unknown opcodes land in ill
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_RTYPE: begin
        if (funct == FN_JR) begin
          dec.cls.jr = 1'b1;
        end else begin
          dec.cls.rtype = 1'b1;
          dec.alu_op    = funct_alu_op(funct);
        end
      end
      OPC_ADDI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = OP_ADD;
        dec.alu_src  = ALU_SRC_SEXT_IMM16;
      end
      OPC_ANDI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = OP_AND;
        dec.alu_src  = ALU_SRC_ZEXT_IMM16;
      end
      OPC_ORI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = OP_OR;
        dec.alu_src  = ALU_SRC_ZEXT_IMM16;
      end
      OPC_LW: begin
        dec.cls.lw  = 1'b1;
        dec.alu_op  = OP_ADD;
        dec.alu_src = ALU_SRC_SEXT_IMM16;
      end
      OPC_SW: begin
        dec.cls.sw  = 1'b1;
        dec.alu_op  = OP_ADD;
        dec.alu_src = ALU_SRC_SEXT_IMM16;
      end
      OPC_BEQ: begin
        dec.cls.beq = 1'b1;
        dec.alu_op  = OP_SUB;
      end
      OPC_BNE: begin
        dec.cls.bne = 1'b1;
        dec.alu_op  = OP_SUB;
      end
      OPC_J:   dec.cls.j   = 1'b1;
      OPC_JAL: dec.cls.jal = 1'b1;
      default: dec.cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP
// with a req/ready memory handshake on a shared memory.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t    state_q;
  state_t    state_d;
  decoded_t  dec_d;
  decoded_t  dec_q;
  op_class_t c;

  mc_opclass u_opclass (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .dec    (dec_d)
  );

  assign c = dec_q.cls;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Class latched while the IR is being decoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dec_q <= '0;
    else if (state_q == S_DECODE) dec_q <= dec_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_d.cls.ill ? S_TRAP : S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          c.rtype, c.ialu: state_d = S_WB;
          c.lw, c.sw:      state_d = S_MEM;
          c.ill:           state_d = S_TRAP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)
          state_d = c.lw ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath controls; all forced low while reset is held
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = ADDR_PC;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_SRC_PC4;
    bus.reg_write    = 1'b0;
    bus.dst_sel      = DST_RT;
    bus.wb_sel       = WB_ALU;
    bus.alu_src      = ALU_SRC_REG;
    bus.alu_op       = 3'd0;
    bus.retire       = 1'b0;
    bus.trap         = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          bus.alu_op  = dec_q.alu_op;
          bus.alu_src = dec_q.alu_src;
          unique case (1'b1)
            c.beq, c.bne: begin
              bus.pc_src   = PC_SRC_BRANCH;
              bus.pc_write = c.beq ? bus.zero : ~bus.zero;
              bus.retire   = 1'b1;
            end
            c.j: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = PC_SRC_JUMP26;
              bus.retire   = 1'b1;
            end
            c.jal: begin
              bus.pc_write  = 1'b1;
              bus.pc_src    = PC_SRC_JUMP26;
              // a link into $zero would be discarded anyway
              bus.reg_write = (RA_REG != 5'd0);
              bus.dst_sel   = DST_RA;
              bus.wb_sel    = WB_PC;
              bus.retire    = 1'b1;
            end
            c.jr: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = PC_SRC_REG;
              bus.retire   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = ADDR_ALU;
          bus.mem_we       = c.sw;
          bus.alu_op       = dec_q.alu_op;
          bus.alu_src      = dec_q.alu_src;
          bus.retire       = c.sw & bus.mem_ready;
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
          unique case (1'b1)
            c.lw: begin
              bus.wb_sel  = WB_MEM;
              bus.dst_sel = DST_RT;
            end
            c.rtype: begin
              bus.dst_sel = DST_RD;
              bus.alu_op  = dec_q.alu_op;
              bus.alu_src = dec_q.alu_src;
            end
            c.ialu: begin
              bus.alu_op  = dec_q.alu_op;
              bus.alu_src = dec_q.alu_src;
            end
            default: ;
          endcase
        end
        S_TRAP:  bus.trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Per-cycle expected outputs come from a per-class phase model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] dst_sel;
    logic [1:0] wb_sel;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic       retire;
    logic       trap;
  } out_t;

  localparam int K_R = 0, K_JR = 1, K_IALU = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  out_t act;
  out_t eq[$];
  out_t mq[$];
  logic rq[$];

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.RA_REG(5'd31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel,
                bus.ir_write, bus.pc_write, bus.pc_src,
                bus.reg_write, bus.dst_sel, bus.wb_sel,
                bus.alu_src, bus.alu_op, bus.retire, bus.trap};

  function automatic int kind(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:               return (f == 6'h08) ? K_JR : K_R;
      6'h08, 6'h0C, 6'h0D: return K_IALU;
      6'h23:               return K_LW;
      6'h2B:               return K_SW;
      6'h04:               return K_BEQ;
      6'h05:               return K_BNE;
      6'h02:               return K_J;
      6'h03:               return K_JAL;
      default:             return K_ILL;
    endcase
  endfunction

  // MIPS semantics: which ALU operation an instruction needs
  function automatic logic [4:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        case (f)
          6'h22:   return {OP_SUB, ALU_SRC_REG};
          6'h24:   return {OP_AND, ALU_SRC_REG};
          6'h25:   return {OP_OR, ALU_SRC_REG};
          6'h2A:   return {OP_SLT, ALU_SRC_REG};
          default: return {OP_ADD, ALU_SRC_REG};
        endcase
      end
      6'h0C:        return {OP_AND, ALU_SRC_ZEXT_IMM16};
      6'h0D:        return {OP_OR, ALU_SRC_ZEXT_IMM16};
      6'h04, 6'h05: return {OP_SUB, ALU_SRC_REG};
      default:      return {OP_ADD, ALU_SRC_SEXT_IMM16};
    endcase
  endfunction

  task automatic push(input out_t e, input logic alu_care, input logic r);
    out_t m;
    m = '1;
    if (!alu_care) begin
      m.alu_op  = '0;
      m.alu_src = '0;
    end
    eq.push_back(e);
    mq.push_back(m);
    rq.push_back(r);
  endtask

  // Build the expected trace of one instruction, then play it
  task automatic run_instr(input string name, input logic [5:0] opc,
                           input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int   k;
    out_t o;
    k = kind(opc, fn);
    eq.delete(); mq.delete(); rq.delete();
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_req = 1'b1;
      push(o, 1'b1, 1'b0);
    end
    o = '0; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1, 1'b1);
    o = '0;
    push(o, 1'b1, 1'($urandom));
    if (k == K_ILL) begin
      for (int i = 0; i < 20; i++) begin
        o = '0; o.trap = 1'b1;
        push(o, 1'b1, 1'($urandom));
      end
    end else begin
      o = '0;
      case (k)
        K_R, K_IALU, K_LW, K_SW: {o.alu_op, o.alu_src} = alu_of(opc, fn);
        K_BEQ, K_BNE: begin
          {o.alu_op, o.alu_src} = alu_of(opc, fn);
          o.pc_src = PC_SRC_BRANCH;
          o.pc_write = (k == K_BEQ) ? z : ~z;
          o.retire = 1'b1;
        end
        K_J: begin
          o.pc_write = 1'b1; o.pc_src = PC_SRC_JUMP26; o.retire = 1'b1;
        end
        K_JAL: begin
          o.pc_write = 1'b1; o.pc_src = PC_SRC_JUMP26; o.retire = 1'b1;
          o.reg_write = 1'b1; o.dst_sel = DST_RA; o.wb_sel = WB_PC;
        end
        default: begin
          o.pc_write = 1'b1; o.pc_src = PC_SRC_REG; o.retire = 1'b1;
        end
      endcase
      push(o, 1'b1, 1'($urandom));
      if (k == K_LW || k == K_SW) begin
        o = '0; o.mem_req = 1'b1; o.mem_addr_sel = ADDR_ALU;
        o.mem_we = (k == K_SW);
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'b0);
        o.retire = (k == K_SW);
        push(o, 1'b0, 1'b1);
      end
      if (k == K_R || k == K_IALU || k == K_LW) begin
        o = '0; o.reg_write = 1'b1; o.retire = 1'b1;
        if (k == K_LW) begin
          o.wb_sel = WB_MEM; o.dst_sel = DST_RT;
        end else begin
          o.wb_sel = WB_ALU;
          o.dst_sel = (k == K_R) ? DST_RD : DST_RT;
          {o.alu_op, o.alu_src} = alu_of(opc, fn);
        end
        push(o, k != K_LW, 1'($urandom));
      end
    end
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      bus.mem_ready = rq[i];
      bus.zero = z;
      if (i <= fw) begin
        bus.opcode = 6'($urandom);
        bus.funct = 6'($urandom);
      end else begin
        bus.opcode = opc;
        bus.funct = fn;
      end
      #1;
      checks++;
      if ((act & mq[i]) !== (eq[i] & mq[i])) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h expected=%h mask=%h",
                 name, i + 1, act, eq[i], mq[i]);
      end
    end
  endtask

  // Release reset away from a clock edge; FETCH requests at once
  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL release_mem_req got=%b expected=1", bus.mem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.opcode = 6'($urandom);
      #1;
      checks++;
      if (act !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=%h expected=0", act);
      end
    end
    release_reset();
  endtask

  task automatic test_rtype_add();
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("sub", 6'h00, 6'h22, 1'b1, 1, 0);
    run_instr("ori", 6'h0D, 6'h15, 1'b0, 0, 0);
  endtask

  task automatic test_lw_stall();
    run_instr("lw_stall", 6'h23, 6'h04, 1'b0, 3, 2);
    run_instr("sw_stall", 6'h2B, 6'h08, 1'b1, 2, 3);
  endtask

  task automatic test_branch();
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    run_instr("beq_z1", 6'h04, 6'h11, 1'b1, 0, 0);
    run_instr("beq_z0", 6'h04, 6'h11, 1'b0, 0, 0);
  endtask

  task automatic test_jumps();
    run_instr("jal", 6'h03, 6'h3F, 1'b0, 0, 0);
    run_instr("j", 6'h02, 6'h00, 1'b1, 1, 0);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] opcs [15];
    logic [5:0] fns [15];
    int         p;
    opcs = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C,
             6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h00,
             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(14, 0));
      run_instr("random", opcs[p],
                (opcs[p] == 6'h00) ? fns[p] : 6'($urandom),
                1'($urandom), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL midfetch_req got=%b expected=1", bus.mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL midfetch_drop got=%h expected=0", act);
    end
    release_reset();
    run_instr("after_reset", 6'h08, 6'h01, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'h3F, 6'h00, 1'b0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.trap !== 1'b0) begin
      failures++;
      $display("FAIL trap_reset got=%b expected=0", bus.trap);
    end
    release_reset();
    run_instr("post_trap", 6'h00, 6'h25, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_stall();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_reset_mid_fetch();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
